// File: rtl/cq_handler.sv
// NVMe completion-queue handler: accepts 16B CQ entries from the SSD over an AXI slave port,
// rings the CQ head doorbell on the NVMe master port and returns host write responses in CID order.
module cq_handler #(
  parameter int unsigned OUTSTANDING   = 16,
  parameter int unsigned NS_ID_WIDTH   = 4,
  parameter int unsigned NS_ADDR_WIDTH = 32,
  parameter int unsigned NS_DATA_WIDTH = 128,
  parameter int unsigned NM_ADDR_WIDTH = 32,
  parameter int unsigned NM_DATA_WIDTH = 128,
  parameter logic [NS_ADDR_WIDTH-1:0] CQ_BASE      = 32'h20400,
  parameter logic [NM_ADDR_WIDTH-1:0] CQ_HDBL_ADDR = 32'h100C
) (
  input  logic                       clk,
  input  logic                       rst,
  // SSD completion writes
  input  logic [NS_ID_WIDTH-1:0]     ns_awid,
  input  logic [NS_ADDR_WIDTH-1:0]   ns_awaddr,
  input  logic [7:0]                 ns_awlen,
  input  logic [2:0]                 ns_awsize,
  input  logic [1:0]                 ns_awburst,
  input  logic                       ns_awvalid,
  output logic                       ns_awready,
  input  logic [NS_DATA_WIDTH-1:0]   ns_wdata,
  input  logic [NS_DATA_WIDTH/8-1:0] ns_wstrb,
  input  logic                       ns_wlast,
  input  logic                       ns_wvalid,
  output logic                       ns_wready,
  output logic [NS_ID_WIDTH-1:0]     ns_bid,
  output logic [1:0]                 ns_bresp,
  output logic                       ns_bvalid,
  input  logic                       ns_bready,
  // CQ head doorbell writes
  output logic [NM_ADDR_WIDTH-1:0]   nm_awaddr,
  output logic [7:0]                 nm_awlen,
  output logic [2:0]                 nm_awsize,
  output logic [1:0]                 nm_awburst,
  output logic                       nm_awvalid,
  input  logic                       nm_awready,
  output logic [NM_DATA_WIDTH-1:0]   nm_wdata,
  output logic [NM_DATA_WIDTH/8-1:0] nm_wstrb,
  output logic                       nm_wlast,
  output logic                       nm_wvalid,
  input  logic                       nm_wready,
  input  logic [1:0]                 nm_bresp,
  input  logic                       nm_bvalid,
  output logic                       nm_bready,
  // Host write completions
  output logic [1:0]                 hp_bresp,
  output logic                       hp_bvalid,
  input  logic                       hp_bready,
  output logic [$clog2(OUTSTANDING)-1:0] cqdb_sqhead
);

  localparam int unsigned IdxW = $clog2(OUTSTANDING);
  localparam logic [NS_ADDR_WIDTH-1:0] CqEnd = CQ_BASE + NS_ADDR_WIDTH'(OUTSTANDING * 16);
  localparam int unsigned DbLane = 32'(CQ_HDBL_ADDR[3:0]);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(OUTSTANDING - 1);

  typedef enum logic [2:0] {StAw, StW, StB, StDb, StDbb} state_e;

  state_e                   state_q, state_d;
  logic [NS_ID_WIDTH-1:0]   id_q, id_d;
  logic [NS_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]               len_q, len_d;
  logic                     first_q, first_d;
  logic [1:0]               bresp_q, bresp_d;
  logic                     entry_ok_q, entry_ok_d;
  logic [IdxW-1:0]          cq_head_q, cq_head_d;
  logic                     phase_q, phase_d;
  logic [IdxW-1:0]          sqhead_q, sqhead_d;
  logic [OUTSTANDING-1:0]   done_q, done_d;
  logic [OUTSTANDING-1:0]   err_q, err_d;
  logic [IdxW-1:0]          hp_ptr_q, hp_ptr_d;
  logic                     aw_done_q, aw_done_d;
  logic                     w_done_q, w_done_d;

  logic            shape_ok, ent_valid, w_hs, parse, commit;
  logic            aw_hs_nm, w_hs_nm, hp_hs;
  logic [IdxW-1:0] ent_cid, ent_sqhd;
  logic [14:0]     ent_status;
  logic            unused_in;

  assign unused_in = ^{ns_awsize, ns_awburst, ns_wstrb, nm_bresp, ns_wdata};

  // Entry decode is only meaningful on the first beat; multi-beat writes are rejected by shape.
  assign shape_ok   = (addr_q >= CQ_BASE) && (addr_q < CqEnd) && (addr_q[3:0] == 4'd0) &&
                      (len_q == 8'd0);
  assign ent_sqhd   = ns_wdata[64 +: IdxW];
  assign ent_cid    = ns_wdata[96 +: IdxW];
  assign ent_status = ns_wdata[127:113];
  assign ent_valid  = shape_ok && (ns_wdata[112] == phase_q);
  assign w_hs       = (state_q == StW) && ns_wvalid;
  assign parse      = w_hs && first_q;
  assign commit     = parse && ns_wlast && ent_valid;

  assign hp_bvalid  = done_q[hp_ptr_q];
  assign hp_bresp   = (done_q[hp_ptr_q] && err_q[hp_ptr_q]) ? 2'b10 : 2'b00;
  assign hp_hs      = hp_bvalid && hp_bready;
  assign cqdb_sqhead = sqhead_q;

  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    addr_d     = addr_q;
    len_d      = len_q;
    first_d    = first_q;
    bresp_d    = bresp_q;
    entry_ok_d = entry_ok_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    ns_awready = 1'b0;
    ns_wready  = 1'b0;
    ns_bvalid  = 1'b0;
    nm_awvalid = 1'b0;
    nm_wvalid  = 1'b0;
    nm_bready  = 1'b0;
    aw_hs_nm   = 1'b0;
    w_hs_nm    = 1'b0;

    unique case (state_q)
      StAw: begin
        ns_awready = !rst;
        if (ns_awvalid && !rst) begin
          id_d    = ns_awid;
          addr_d  = ns_awaddr;
          len_d   = ns_awlen;
          first_d = 1'b1;
          state_d = StW;
        end
      end
      StW: begin
        ns_wready = 1'b1;
        if (parse) begin
          first_d    = 1'b0;
          bresp_d    = shape_ok ? 2'b00 : 2'b10;
          entry_ok_d = ent_valid && ns_wlast;
        end
        if (w_hs && ns_wlast) state_d = StB;
      end
      StB: begin
        ns_bvalid = 1'b1;
        if (ns_bready) state_d = entry_ok_q ? StDb : StAw;
      end
      StDb: begin
        nm_awvalid = !aw_done_q;
        nm_wvalid  = !w_done_q;
        aw_hs_nm   = nm_awvalid && nm_awready;
        w_hs_nm    = nm_wvalid && nm_wready;
        aw_done_d  = aw_done_q || aw_hs_nm;
        w_done_d   = w_done_q || w_hs_nm;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StDbb;
        end
      end
      StDbb: begin
        nm_bready = 1'b1;
        if (nm_bvalid) state_d = StAw;
      end
      default: state_d = StAw;
    endcase
  end

  always_comb begin
    cq_head_d = cq_head_q;
    phase_d   = phase_q;
    sqhead_d  = sqhead_q;
    done_d    = done_q;
    err_d     = err_q;
    hp_ptr_d  = hp_ptr_q;
    if (commit) begin
      sqhead_d  = ent_sqhd;
      cq_head_d = (cq_head_q == LastIdx) ? '0 : cq_head_q + 1'b1;
      if (cq_head_q == LastIdx) phase_d = !phase_q;
      // A duplicate completion for a CID still pending is dropped.
      if (!done_q[ent_cid]) begin
        done_d[ent_cid] = 1'b1;
        err_d[ent_cid]  = (ent_status != 15'd0);
      end
    end
    if (hp_hs) begin
      done_d[hp_ptr_q] = 1'b0;
      hp_ptr_d = (hp_ptr_q == LastIdx) ? '0 : hp_ptr_q + 1'b1;
    end
  end

  always_comb begin
    ns_bid     = ns_bvalid ? id_q : '0;
    ns_bresp   = ns_bvalid ? bresp_q : 2'b00;
    nm_awaddr  = nm_awvalid ? CQ_HDBL_ADDR : '0;
    nm_awlen   = 8'd0;
    nm_awsize  = nm_awvalid ? 3'd2 : 3'd0;
    nm_awburst = nm_awvalid ? 2'd1 : 2'd0;
    nm_wdata   = '0;
    nm_wstrb   = '0;
    nm_wlast   = nm_wvalid;
    if (nm_wvalid) begin
      nm_wdata[DbLane*8 +: 32] = 32'(cq_head_q);
      nm_wstrb[DbLane +: 4]    = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAw;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      first_q    <= 1'b0;
      bresp_q    <= 2'b00;
      entry_ok_q <= 1'b0;
      cq_head_q  <= '0;
      phase_q    <= 1'b1;
      sqhead_q   <= '0;
      done_q     <= '0;
      err_q      <= '0;
      hp_ptr_q   <= '0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      id_q       <= id_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      first_q    <= first_d;
      bresp_q    <= bresp_d;
      entry_ok_q <= entry_ok_d;
      cq_head_q  <= cq_head_d;
      phase_q    <= phase_d;
      sqhead_q   <= sqhead_d;
      done_q     <= done_d;
      err_q      <= err_d;
      hp_ptr_q   <= hp_ptr_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
    end
  end

endmodule

// File: tb/tb_cq_handler.sv
// Randomized bench for cq_handler: drives CQ entries and doorbell/host handshakes and compares
// against a queue-level model of CQ head, phase, SQ head and in-order host completions.
module tb_cq_handler;

  localparam logic [31:0] Base   = 32'h20400;
  localparam logic [31:0] DbAddr = 32'h100C;

  logic         clk, rst;
  logic [3:0]   ns_awid;
  logic [31:0]  ns_awaddr;
  logic [7:0]   ns_awlen;
  logic [2:0]   ns_awsize;
  logic [1:0]   ns_awburst;
  logic         ns_awvalid, ns_awready;
  logic [127:0] ns_wdata;
  logic [15:0]  ns_wstrb;
  logic         ns_wlast, ns_wvalid, ns_wready;
  logic [3:0]   ns_bid;
  logic [1:0]   ns_bresp;
  logic         ns_bvalid, ns_bready;
  logic [31:0]  nm_awaddr;
  logic [7:0]   nm_awlen;
  logic [2:0]   nm_awsize;
  logic [1:0]   nm_awburst;
  logic         nm_awvalid, nm_awready;
  logic [127:0] nm_wdata;
  logic [15:0]  nm_wstrb;
  logic         nm_wlast, nm_wvalid, nm_wready;
  logic [1:0]   nm_bresp;
  logic         nm_bvalid, nm_bready;
  logic [1:0]   hp_bresp;
  logic         hp_bvalid, hp_bready;
  logic [3:0]   cqdb_sqhead;

  cq_handler dut (
    .clk(clk), .rst(rst),
    .ns_awid(ns_awid), .ns_awaddr(ns_awaddr), .ns_awlen(ns_awlen), .ns_awsize(ns_awsize),
    .ns_awburst(ns_awburst), .ns_awvalid(ns_awvalid), .ns_awready(ns_awready),
    .ns_wdata(ns_wdata), .ns_wstrb(ns_wstrb), .ns_wlast(ns_wlast), .ns_wvalid(ns_wvalid),
    .ns_wready(ns_wready), .ns_bid(ns_bid), .ns_bresp(ns_bresp), .ns_bvalid(ns_bvalid),
    .ns_bready(ns_bready),
    .nm_awaddr(nm_awaddr), .nm_awlen(nm_awlen), .nm_awsize(nm_awsize), .nm_awburst(nm_awburst),
    .nm_awvalid(nm_awvalid), .nm_awready(nm_awready), .nm_wdata(nm_wdata), .nm_wstrb(nm_wstrb),
    .nm_wlast(nm_wlast), .nm_wvalid(nm_wvalid), .nm_wready(nm_wready), .nm_bresp(nm_bresp),
    .nm_bvalid(nm_bvalid), .nm_bready(nm_bready),
    .hp_bresp(hp_bresp), .hp_bvalid(hp_bvalid), .hp_bready(hp_bready),
    .cqdb_sqhead(cqdb_sqhead)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [15:0] mdone = '0;
  logic [15:0] merr  = '0;
  int          mptr  = 0;
  int          mhead = 0;
  logic        mphase = 1'b1;
  int          msq   = 0;
  logic        ev_set = 1'b0;
  logic [3:0]  ev_cid = '0;
  logic        ev_err = 1'b0;
  logic        hs = 1'b0;
  logic        mon_en = 1'b0;
  int          hp_pct = 100;

  // Host-side monitor: the next response is the oldest CID, valid only once that CID completed.
  initial begin
    hp_bready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst || !mon_en) begin
        hs = 1'b0;
        hp_bready = 1'b0;
      end else begin
        check_eq("hp_bvalid", 128'(hp_bvalid), 128'(mdone[mptr]));
        if (mdone[mptr]) check_eq("hp_bresp", 128'(hp_bresp), merr[mptr] ? 128'(2) : 128'(0));
        hp_bready = ($urandom_range(99) < hp_pct);
        hs = mdone[mptr] && hp_bready;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      if (rst) begin
        mdone = '0;
        merr  = '0;
        mptr  = 0;
      end else begin
        if (ev_set && !mdone[ev_cid]) begin
          mdone[ev_cid] = 1'b1;
          merr[ev_cid]  = ev_err;
        end
        if (hs) begin
          mdone[mptr] = 1'b0;
          mptr = (mptr + 1) % 16;
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    ns_awvalid = 1'b0; ns_wvalid = 1'b0; ns_wlast = 1'b0; ns_bready = 1'b0;
    nm_awready = 1'b0; nm_wready = 1'b0; nm_bvalid = 1'b0; nm_bresp = 2'b00;
    ev_set = 1'b0;
    #1;
    check_eq("rst_awready", 128'(ns_awready), 128'(0));
    check_eq("rst_wready", 128'(ns_wready), 128'(0));
    check_eq("rst_bvalid", 128'(ns_bvalid), 128'(0));
    check_eq("rst_nm_valid", 128'({nm_awvalid, nm_wvalid, nm_bready}), 128'(0));
    check_eq("rst_hp_bvalid", 128'(hp_bvalid), 128'(0));
    check_eq("rst_sqhead", 128'(cqdb_sqhead), 128'(0));
    check_eq("rst_nm_data", nm_wdata | 128'(nm_awaddr), 128'(0));
    mhead = 0; mphase = 1'b1; msq = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("post_rst_awready", 128'(ns_awready), 128'(1));
  endtask

  task automatic send_entry(input logic [31:0] addr, input logic [7:0] len, input logic [15:0] cid,
                            input logic [15:0] sqhd, input logic [14:0] status, input logic ph,
                            input int da, input int dw, input bit rst_in_db);
    logic         shape, valid;
    logic [3:0]   id;
    logic [127:0] data;
    int           n, aw_cnt, w_cnt, cyc;
    shape = (addr >= Base) && (addr < Base + 32'd256) && (addr[3:0] == 4'd0) && (len == 8'd0);
    valid = shape && (ph == mphase);
    id    = 4'($urandom_range(15));
    data  = {$urandom(), $urandom(), $urandom(), $urandom()};
    data[64 +: 16]  = sqhd;
    data[96 +: 16]  = cid;
    data[112]       = ph;
    data[127:113]   = status;

    ns_awvalid = 1'b1; ns_awid = id; ns_awaddr = addr; ns_awlen = len;
    ns_awsize = 3'd4; ns_awburst = 2'd1;
    n = 0;
    while (!ns_awready && n < 20) begin @(negedge clk); n++; end
    check_eq("ns_awready", 128'(ns_awready), 128'(1));
    @(posedge clk); @(negedge clk);
    ns_awvalid = 1'b0;

    for (int b = 0; b <= int'(len); b++) begin
      ns_wvalid = 1'b1;
      ns_wdata  = (b == 0) ? data : {$urandom(), $urandom(), $urandom(), $urandom()};
      ns_wstrb  = '1;
      ns_wlast  = (b == int'(len));
      n = 0;
      while (!ns_wready && n < 20) begin @(negedge clk); n++; end
      check_eq("ns_wready", 128'(ns_wready), 128'(1));
      if (b == int'(len) && valid) begin
        ev_set = 1'b1; ev_cid = cid[3:0]; ev_err = (status != 15'd0);
      end
      @(posedge clk); @(negedge clk);
      ev_set = 1'b0;
    end
    ns_wvalid = 1'b0; ns_wlast = 1'b0;

    if (valid) begin
      msq   = int'(sqhd[3:0]);
      mhead = (mhead + 1) % 16;
      if (mhead == 0) mphase = ~mphase;
    end
    check_eq("cqdb_sqhead", 128'(cqdb_sqhead), 128'(msq));

    n = 0;
    while (!ns_bvalid && n < 20) begin @(negedge clk); n++; end
    check_eq("ns_bvalid", 128'(ns_bvalid), 128'(1));
    check_eq("ns_bresp", 128'(ns_bresp), shape ? 128'(0) : 128'(2));
    check_eq("ns_bid", 128'(ns_bid), 128'(id));
    repeat ($urandom_range(2)) @(negedge clk);
    ns_bready = 1'b1;
    @(posedge clk); @(negedge clk);
    ns_bready = 1'b0;

    if (!valid) begin
      repeat (3) begin
        check_eq("no_doorbell", 128'({nm_awvalid, nm_wvalid}), 128'(0));
        @(negedge clk);
      end
      check_eq("idle_awready", 128'(ns_awready), 128'(1));
      return;
    end

    if (rst_in_db) begin
      check_eq("db_valid", 128'({nm_awvalid, nm_wvalid}), 128'(3));
      do_reset();
      return;
    end

    aw_cnt = 0; w_cnt = 0; cyc = 0;
    while ((aw_cnt == 0 || w_cnt == 0) && cyc < 40) begin
      nm_awready = (cyc >= da);
      nm_wready  = (cyc >= dw);
      if (nm_awvalid && nm_awready) begin
        aw_cnt++;
        check_eq("db_awaddr", 128'(nm_awaddr), 128'(DbAddr));
        check_eq("db_awattr", 128'({nm_awlen, nm_awsize, nm_awburst}), 128'({8'd0, 3'd2, 2'd1}));
      end
      if (nm_wvalid && nm_wready) begin
        w_cnt++;
        check_eq("db_wdata", nm_wdata, 128'(mhead) << 96);
        check_eq("db_wstrb", 128'({nm_wstrb, nm_wlast}), 128'({16'hF000, 1'b1}));
      end
      @(posedge clk); @(negedge clk);
      cyc++;
    end
    nm_awready = 1'b0; nm_wready = 1'b0;
    check_eq("db_aw_count", 128'(aw_cnt), 128'(1));
    check_eq("db_w_count", 128'(w_cnt), 128'(1));
    check_eq("dbb_state", 128'({nm_awvalid, nm_wvalid, nm_bready}), 128'(1));
    repeat ($urandom_range(2)) @(negedge clk);
    nm_bvalid = 1'b1; nm_bresp = 2'($urandom_range(3));
    @(posedge clk); @(negedge clk);
    nm_bvalid = 1'b0;
    check_eq("back_to_aw", 128'(ns_awready), 128'(1));
  endtask

  initial begin
    logic [31:0] addr;
    logic [7:0]  len;
    logic        ph;
    logic [14:0] st;
    int          r;
    rst = 1'b1;
    ns_awid = '0; ns_awaddr = '0; ns_awlen = '0; ns_awsize = '0; ns_awburst = '0;
    ns_wdata = '0; ns_wstrb = '0;
    do_reset();
    mon_en = 1'b1;

    // Single entry
    send_entry(Base, 8'd0, 16'd0, 16'd1, 15'd0, 1'b1, 0, 0, 1'b0);
    repeat (3) @(negedge clk);

    // Out-of-order CIDs held until the oldest completes
    do_reset();
    hp_pct = 0;
    send_entry(Base, 8'd0, 16'd2, 16'd3, 15'd0, 1'b1, 1, 0, 1'b0);
    send_entry(Base + 32'd16, 8'd0, 16'd0, 16'd4, 15'd0, 1'b1, 0, 1, 1'b0);
    send_entry(Base + 32'd32, 8'd0, 16'd1, 16'd5, 15'd0, 1'b1, 0, 0, 1'b0);
    hp_pct = 100;
    repeat (6) @(negedge clk);

    // Phase wrap
    do_reset();
    for (int i = 0; i < 16; i++)
      send_entry(Base + 32'(i * 16), 8'd0, 16'(i), 16'(i), 15'd0, 1'b1,
                 $urandom_range(3), $urandom_range(3), 1'b0);
    send_entry(Base, 8'd0, 16'd0, 16'd9, 15'd0, 1'b1, 0, 0, 1'b0);
    send_entry(Base, 8'd0, 16'd0, 16'd9, 15'd0, 1'b0, 0, 0, 1'b0);

    // Malformed writes
    send_entry(Base - 32'd16, 8'd0, 16'd5, 16'd7, 15'd0, mphase, 0, 0, 1'b0);
    send_entry(Base + 32'd16, 8'd1, 16'd5, 16'd7, 15'd0, mphase, 0, 0, 1'b0);
    send_entry(Base + 32'd256, 8'd0, 16'd5, 16'd7, 15'd0, mphase, 0, 0, 1'b0);
    send_entry(Base + 32'd20, 8'd0, 16'd5, 16'd7, 15'd0, mphase, 0, 0, 1'b0);

    // Error status and slow doorbell address channel
    send_entry(Base + 32'(mhead * 16), 8'd0, 16'd3, 16'd2, 15'h0001, mphase, 5, 0, 1'b0);

    // Reset during doorbell, then resume
    send_entry(Base + 32'(mhead * 16), 8'd0, 16'd6, 16'd8, 15'd0, mphase, 0, 0, 1'b1);
    send_entry(Base, 8'd0, 16'd0, 16'd11, 15'd0, 1'b1, 0, 0, 1'b0);

    for (int t = 0; t < 200; t++) begin
      hp_pct = 30 + $urandom_range(70);
      r    = $urandom_range(99);
      addr = Base + 32'($urandom_range(15) * 16);
      len  = 8'd0;
      if (r < 4) addr = Base - 32'd16;
      else if (r < 8) addr = Base + 32'd256;
      else if (r < 11) addr = addr + 32'd8;
      else if (r < 14) len = 8'($urandom_range(1, 3));
      ph = ($urandom_range(99) < 10) ? ~mphase : mphase;
      st = ($urandom_range(99) < 70) ? 15'd0 : 15'($urandom_range(1, 32767));
      send_entry(addr, len, 16'($urandom()), 16'($urandom()), st, ph,
                 $urandom_range(6), $urandom_range(6), 1'b0);
    end
    hp_pct = 100;
    repeat (40) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
